// File: rtl/mem_io_responder.sv
// Data-side responder: local block RAM below IO_BASE, ESP32 link above.
// One response pulse per accepted request; bounded wait on the IO link.
module mem_io_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] IO_BASE   = 32'h8000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        io_valid,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RAM,
    IO_WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [31:0] mem [RAM_WORDS];
  logic [15:0] cnt;
  logic [AW-1:0] idx;
  logic        acc;
  logic        mis;
  logic        is_io;
  logic        oor;
  logic        ram_wr;

  assign req_ready = (state == IDLE);
  assign acc       = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];
  assign mis       = req_addr[1:0] != 2'b00;
  assign is_io     = req_addr >= IO_BASE;
  assign oor       = req_addr[31:2] >= 30'(RAM_WORDS);
  assign ram_wr    = !reset && acc && req_we && !mis && !is_io && !oor;

  // Byte-masked RAM write at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Request decode, IO wait with timeout, and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      io_valid  <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
      io_be     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          if (acc) begin
            if (mis) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (is_io) begin
              state    <= IO_WAIT;
              cnt      <= '0;
              io_valid <= 1'b1;
              io_we    <= req_we;
              io_addr  <= req_addr;
              io_wdata <= req_wdata;
              io_be    <= req_be;
            end else if (oor) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= RAM;
              rsp_valid <= 1'b1;
              if (!req_we) rsp_rdata <= mem[idx];
            end
          end
        end
        RAM: begin
          state     <= IDLE;
          rsp_rdata <= '0;
        end
        IO_WAIT: begin
          if (io_ack) begin
            state     <= RESP;
            io_valid  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= io_we ? 32'h0 : io_rdata;
          end else if (cnt == TO_LAST) begin
            state     <= RESP;
            io_valid  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, IO link, errors, reset.
// Expected values are hand-computed constants.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        io_valid;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_ack;
  logic [31:0] io_rdata;

  int total = 0;
  int bad   = 0;
  int k;

  always #5 clk = ~clk;

  mem_io_responder #(
    .RAM_WORDS(1024),
    .IO_BASE  (32'h8000_0000),
    .TIMEOUT  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .io_valid (io_valid),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_be    (io_be),
    .io_ack   (io_ack),
    .io_rdata (io_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic ram_req(input string tag, input logic we,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp_d,
                         input logic exp_e);
    wait_ready(tag);
    issue(we, a, d, be);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rd"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    io_ack    = 1'b0;
    io_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_io", 32'(io_valid), 32'd0);
    chk("rst_rd", rsp_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    ram_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    ram_req("ld10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    ram_req("stb2", 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 32'h0, 1'b0);
    ram_req("ldb2", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0);
    ram_req("stbe0", 1'b1, 32'h10, 32'h11111111, 4'h0, 32'h0, 1'b0);
    ram_req("ldbe0", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0);
    ram_req("st00", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);

    // IO load acked on the 4th io_valid cycle
    wait_ready("iold");
    issue(1'b0, 32'h8000_0004, 32'h0, 4'hF);
    k = 0;
    while (io_valid && k < 20) begin
      k++;
      if (k == 1) begin
        chk("iold_addr", io_addr, 32'h8000_0004);
        chk("iold_we", 32'(io_we), 32'd0);
        chk("iold_rdy", 32'(req_ready), 32'd0);
      end
      if (k == 4) begin
        io_ack   = 1'b1;
        io_rdata = 32'h1234_5678;
      end
      @(posedge clk); #1;
      io_ack = 1'b0;
    end
    chk("iold_cyc", 32'(k), 32'd4);
    chk("iold_vld", 32'(rsp_valid), 32'd1);
    chk("iold_rd", rsp_rdata, 32'h1234_5678);
    chk("iold_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    chk("iold_ready", 32'(req_ready), 32'd1);
    chk("iold_pulse", 32'(rsp_valid), 32'd0);

    // IO store, no ack: timeout after 8 cycles
    wait_ready("iost");
    issue(1'b1, 32'h8000_0100, 32'hA5A5A5A5, 4'h3);
    k = 0;
    while (io_valid && k < 20) begin
      k++;
      if (k == 8) begin
        chk("iost_wd", io_wdata, 32'hA5A5A5A5);
        chk("iost_be", 32'(io_be), 32'h3);
        chk("iost_we", 32'(io_we), 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("iost_cyc", 32'(k), 32'd8);
    chk("iost_vld", 32'(rsp_valid), 32'd1);
    chk("iost_err", 32'(rsp_err), 32'd1);
    chk("iost_rd", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("iost_pulse", 32'(rsp_valid), 32'd0);

    // Error accesses with no side effects
    ram_req("mis13", 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
    ram_req("mis12", 1'b1, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
    ram_req("oor", 1'b1, 32'h1000, 32'h0BADBAD0, 4'hF, 32'h0, 1'b1);
    ram_req("chk10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0);
    ram_req("chk00", 1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

    // Reset in the middle of an IO transaction
    wait_ready("iorst");
    issue(1'b0, 32'h8000_0008, 32'h0, 4'hF);
    chk("iorst_io", 32'(io_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("iorst_iov", 32'(io_valid), 32'd0);
    chk("iorst_rsp", 32'(rsp_valid), 32'd0);
    chk("iorst_rdy", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("iorst_norsp", 32'(rsp_valid), 32'd0);
    ram_req("rst10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0);
    ram_req("rst00", 1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Data-side memory responder for the RV32I CPU: it accepts load and store requests from the MEM stage over a valid/ready handshake. Word-aligned accesses below `IO_BASE` go to local block RAM. Accesses at or above `IO_BASE` are forwarded over a held-valid/ack link to the ESP32 IO controller, with a bounded timeout. Every accepted request produces exactly one response pulse, carrying read data or an error flag.

## Interface
Parameters:
- `RAM_WORDS`, 1024, local RAM depth in 32-bit words (power of two).
- `IO_BASE`, 32'h8000_0000, first address routed to the ESP32 link.
- `TIMEOUT`, 255, maximum cycles `io_valid` stays high without `io_ack` (1..65535).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  CPU request present.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; bit i covers `wdata[8i+7:8i]`.
- `req_ready`  out  1  responder can accept a request this cycle.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  error qualifier, valid with `rsp_valid`.
- `io_valid`  out  1  IO transaction pending to the ESP32.
- `io_we`, `io_addr[31:0]`, `io_wdata[31:0]`, `io_be[3:0]`  out  registered copy of the request.
- `io_ack`  in  1  ESP32 completes the transaction.
- `io_rdata`  in  32  ESP32 load data; valid with `io_ack`.

## Operation
- FSM states: IDLE, RAM, IO_WAIT, RESP.
  - `req_ready` = 1 only in IDLE.
  - A request is accepted on an edge where `req_valid && req_ready`.
- Decode at acceptance, in priority order:
  - `req_addr[1:0] != 0` → error: go to RESP with `rsp_err` = 1 and no side effects.
  - `req_addr >= IO_BASE` → go to IO_WAIT and latch `io_*` from `req_*`.
  - Word index `req_addr[31:2] >= RAM_WORDS` → error, go to RESP.
  - Otherwise → go to RAM.
- RAM accesses:
  - A store writes only the enabled bytes, at the acceptance edge.
  - A load registers the word, and the RAM state drives the response.
  - `req_be` = 0 on a store is a legal no-op.
- RAM state: `rsp_valid` = 1 for one cycle with the read data (0 for stores), then IDLE.
- IO_WAIT:
  - `io_valid` = 1 and the payload is held stable.
  - A 16-bit counter is cleared on entry and increments each cycle.
  - On `io_ack`: capture `io_rdata` (forced to 0 if `io_we`), go to RESP with `rsp_err` = 0.
  - If the counter reaches `TIMEOUT - 1` without an ack: go to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - `io_ack` in the same cycle as the timeout: the ack wins.
- RESP: `rsp_valid` = 1 for one cycle, then IDLE. There is no response backpressure; the CPU must take the pulse.
- `io_ack` outside IO_WAIT is ignored.
- Reset:
  - State goes to IDLE; all outputs are driven to 0, including `io_valid` (dropped at the reset edge, even mid-transaction).
  - A pending request is discarded with no response.
  - RAM contents are not cleared.

## Timing
- The request is accepted at edge E0, in the cycle where `req_valid` and `req_ready` are both high.
- RAM access: `rsp_valid` is high in the cycle after E0. `req_ready` returns the following cycle, giving 1 request per 2 cycles.
- Error access: same timing as a RAM access.
- IO access:
  - `io_valid` rises in the cycle after E0.
  - If `io_ack` is sampled high in cycle A, `io_valid` is low and `rsp_valid` is high in A+1, and `req_ready` is high in A+2.
  - Timeout: `io_valid` is high for exactly `TIMEOUT` cycles, and the error `rsp_valid` falls in the next cycle.
- `req_ready` is a pure state decode and has no combinational path from `req_valid`.
- All outputs are registered except `req_ready`.

## Test plan
- Reset, then store 32'hDEADBEEF to 0x10 with `be` = 4'hF, then load 0x10:
  - Both `rsp_valid` pulses arrive 1 cycle after acceptance.
  - The load returns 32'hDEADBEEF with `rsp_err` = 0.
- Store 32'h00AA0000 with `be` = 4'b0100 over 32'hDEADBEEF at 0x10, then load → 32'hDEAABEEF.
- Load 0x8000_0004 with the ESP32 model acking 3 cycles after `io_valid`, `io_rdata` = 32'h1234_5678:
  - `io_valid` is high for 4 cycles.
  - `rsp_rdata` = 32'h1234_5678, `rsp_err` = 0.
- IO store with `TIMEOUT` = 8 and no ack: `io_valid` is high for exactly 8 cycles, then `rsp_err` = 1 and `rsp_rdata` = 0.
- Error accesses, each with no RAM change and `rsp_err` = 1 after 1 cycle:
  - Load from 0x13 (misaligned).
  - Store to 0x1000 with `RAM_WORDS` = 1024 (out of range).
- Assert `reset` during IO_WAIT: next cycle `io_valid` = 0, `rsp_valid` = 0, `req_ready` = 1, and previously written RAM data is intact.
